// File: rtl/excess3_defs.sv
// Shared definitions for the excess-3 receive path.
//
// Contents:
//   EXCESS3_OFFSET  bias added by the excess-3 encoder
//   EXCESS3_MIN     smallest legal excess-3 code (BCD 0)
//   EXCESS3_MAX     largest legal excess-3 code (BCD 9)
//   BAD_DIGIT       nibble substituted for an illegal code
//   state_t         handshake FSM states of the deserializer
package excess3_defs;

    localparam logic [3:0] EXCESS3_OFFSET = 4'd3;
    localparam logic [3:0] EXCESS3_MIN    = 4'd3;
    localparam logic [3:0] EXCESS3_MAX    = 4'd12;
    localparam logic [3:0] BAD_DIGIT      = 4'hF;

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

endpackage

// File: rtl/excess3_digit_decode.sv
// Combinational excess-3 to BCD digit decoder.
//
// Ports:
//   code     in   4  excess-3 code
//   bcd      out  4  decoded BCD digit, BAD_DIGIT for an illegal code
//   code_ok  out  1  code lies in EXCESS3_MIN..EXCESS3_MAX
module excess3_digit_decode
    import excess3_defs::*;
(
    input  logic [3:0] code,
    output logic [3:0] bcd,
    output logic       code_ok
);

    always_comb begin
        code_ok = (code >= EXCESS3_MIN) && (code <= EXCESS3_MAX);
        // Subtraction cannot wrap: it is only used when code >= EXCESS3_MIN.
        if (code_ok) begin
            bcd = code - EXCESS3_OFFSET;
        end else begin
            bcd = BAD_DIGIT;
        end
    end

endmodule

// File: rtl/excess3_to_bcd_deserializer.sv
// Bit-serial excess-3 receiver that assembles NUM_DIGITS decoded digits
// into one packed BCD word delivered over a valid/ready handshake.
//
// Ports:
//   clk        in   1             system clock, rising edge
//   rst_n      in   1             asynchronous active-low reset
//   in_valid   in   1             in_bit is valid this cycle
//   in_ready   out  1             a bit can be accepted this cycle
//   in_bit     in   1             serial excess-3 bit, digits MSD first,
//                                 bits within a digit LSB first
//   out_valid  out  1             out_bcd/out_err hold a complete frame
//   out_ready  in   1             consumer accepts the frame
//   out_bcd    out  4*NUM_DIGITS  packed BCD, first digit in the top nibble
//   out_err    out  1             at least one digit of the frame was illegal
module excess3_to_bcd_deserializer
    import excess3_defs::*;
#(
    parameter int unsigned NUM_DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_bit,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [4*NUM_DIGITS-1:0] out_bcd,
    output logic                    out_err
);

    localparam int unsigned DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [DW-1:0] LAST_DIGIT = DW'(NUM_DIGITS - 1);

    state_t                  state;
    logic [1:0]              bit_cnt;
    logic [DW-1:0]           digit_cnt;
    logic [3:0]              shift_q;
    logic [4*NUM_DIGITS-1:0] acc_q;
    logic [4*NUM_DIGITS-1:0] out_bcd_q;
    logic                    err_acc_q;
    logic                    out_err_q;
    logic                    out_valid_q;
    logic                    in_ready_q;

    logic                    accept;
    logic                    digit_done;
    logic                    frame_done;
    logic [3:0]              code;
    logic [3:0]              dec_bcd;
    logic                    dec_ok;
    logic [4*NUM_DIGITS-1:0] frame_next;

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_bcd   = out_bcd_q;
    assign out_err   = out_err_q;

    assign accept     = in_valid & in_ready_q;
    assign digit_done = accept && (bit_cnt == 2'd3);
    assign frame_done = digit_done && (digit_cnt == LAST_DIGIT);

    // The 4th bit is still on the wire, so the completed code is formed
    // from the three stored bits plus the live input bit.
    assign code = {in_bit, shift_q[2:0]};

    excess3_digit_decode u_digit_decode (
        .code    (code),
        .bcd     (dec_bcd),
        .code_ok (dec_ok)
    );

    // Accumulated frame with the digit just completed dropped into its slot.
    always_comb begin
        frame_next = acc_q;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (DW'(i) == digit_cnt) begin
                frame_next[(NUM_DIGITS - 1 - i) * 4 +: 4] = dec_bcd;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= COLLECT;
            bit_cnt     <= '0;
            digit_cnt   <= '0;
            shift_q     <= '0;
            acc_q       <= '0;
            out_bcd_q   <= '0;
            err_acc_q   <= 1'b0;
            out_err_q   <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            case (state)
                COLLECT: begin
                    in_ready_q <= 1'b1;
                    if (accept) begin
                        if (digit_done) begin
                            bit_cnt <= '0;
                            shift_q <= '0;
                            if (frame_done) begin
                                digit_cnt   <= '0;
                                acc_q       <= '0;
                                err_acc_q   <= 1'b0;
                                out_bcd_q   <= frame_next;
                                out_err_q   <= err_acc_q | ~dec_ok;
                                out_valid_q <= 1'b1;
                                in_ready_q  <= 1'b0;
                                state       <= HOLD;
                            end else begin
                                digit_cnt <= digit_cnt + 1'b1;
                                acc_q     <= frame_next;
                                err_acc_q <= err_acc_q | ~dec_ok;
                            end
                        end else begin
                            shift_q[bit_cnt] <= in_bit;
                            bit_cnt          <= bit_cnt + 2'd1;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= COLLECT;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_excess3_to_bcd_deserializer.sv
module tb_excess3_to_bcd_deserializer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_bit;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_bcd;
    logic        out_err;

    int errors;
    int checks;

    excess3_to_bcd_deserializer #(.NUM_DIGITS(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bit    (in_bit),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bcd   (out_bcd),
        .out_err   (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Presents one bit and returns #1 after the edge that accepted it.
    // in_valid is left high so consecutive calls form a continuous stream.
    task automatic send_bit(input logic b);
        int k;
        in_valid = 1'b1;
        in_bit   = b;
        k = 0;
        while (!in_ready && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        if (k >= 50) begin
            checks++;
            errors++;
            $display("FAIL send_bit_timeout: in_ready=%b required 1 within 50 cycles", in_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic send_code(input logic [3:0] c);
        for (int i = 0; i < 4; i++) send_bit(c[i]);
    endtask

    // codes[15:12] is digit 0 (sent first); optional idle gaps of 0..3 cycles.
    task automatic send_frame(input logic [15:0] codes, input bit gaps);
        logic [3:0] c;
        for (int d = 0; d < 4; d++) begin
            c = codes[(3 - d) * 4 +: 4];
            for (int i = 0; i < 4; i++) begin
                if (gaps) begin
                    int n;
                    n = $urandom_range(3, 0);
                    in_valid = 1'b0;
                    for (int g = 0; g < n; g++) begin
                        @(posedge clk); #1;
                    end
                end
                send_bit(c[i]);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic do_handshake(input string name);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_valid_drop: out_valid=%b required 0", name, out_valid);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_ready_return: in_ready=%b required 1", name, in_ready);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b0; in_bit = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL reset_in_ready: got %b required 0", in_ready);
        end
        checks++;
        if ({out_valid, out_err, out_bcd} !== 18'h0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b err=%b bcd=%h required 0/0/0000", out_valid, out_err, out_bcd);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_release_ready: got %b required 1", in_ready);
        end
    endtask

    task automatic test_basic;
        send_code(4'b0100);
        send_code(4'b0101);
        send_code(4'b0110);
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL basic_early_valid: out_valid=%b required 0 after 15 bits", out_valid);
        end
        send_bit(1'b0);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL basic_valid: out_valid=%b in_ready=%b required 1/0", out_valid, in_ready);
        end
        checks++;
        if (out_bcd !== 16'h1234 || out_err !== 1'b0) begin
            errors++; $display("FAIL basic_data: bcd=%h err=%b required 1234/0", out_bcd, out_err);
        end
        do_handshake("basic");
    endtask

    task automatic test_boundary;
        send_frame(16'b0011_1100_0011_1100, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_bcd !== 16'h0909 || out_err !== 1'b0) begin
            errors++;
            $display("FAIL boundary_data: valid=%b bcd=%h err=%b required 1/0909/0", out_valid, out_bcd, out_err);
        end
        do_handshake("boundary");
    endtask

    task automatic test_error;
        send_frame(16'b1000_1001_1010_0000, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_bcd !== 16'h567F || out_err !== 1'b1) begin
            errors++;
            $display("FAIL error_single: valid=%b bcd=%h err=%b required 1/567f/1", out_valid, out_bcd, out_err);
        end
        do_handshake("error1");
        send_frame(16'b0100_0100_0100_0100, 1'b0);
        checks++;
        if (out_bcd !== 16'h1111 || out_err !== 1'b0) begin
            errors++; $display("FAIL error_clears: bcd=%h err=%b required 1111/0", out_bcd, out_err);
        end
        do_handshake("error2");
        // 0010 just below, 1101 just above the legal range
        send_frame(16'b0010_1101_0111_1111, 1'b0);
        checks++;
        if (out_bcd !== 16'hFF4F || out_err !== 1'b1) begin
            errors++; $display("FAIL error_multi: bcd=%h err=%b required ff4f/1", out_bcd, out_err);
        end
        do_handshake("error3");
    endtask

    task automatic test_backpressure;
        send_frame(16'b0100_0101_0110_0111, 1'b0);
        in_valid = 1'b1;
        in_bit   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_bcd !== 16'h1234 || out_err !== 1'b0) begin
                errors++;
                $display("FAIL backpressure_hold%0d: ready=%b valid=%b bcd=%h err=%b required 0/1/1234/0",
                         i, in_ready, out_valid, out_bcd, out_err);
            end
        end
        do_handshake("backpressure");
    endtask

    task automatic test_gaps;
        send_frame(16'b1100_1011_1010_1001, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_bcd !== 16'h9876 || out_err !== 1'b0) begin
            errors++;
            $display("FAIL gaps_data: valid=%b bcd=%h err=%b required 1/9876/0", out_valid, out_bcd, out_err);
        end
        do_handshake("gaps");
    endtask

    task automatic test_mid_reset;
        send_code(4'b1000);
        send_bit(1'b1); send_bit(1'b0);
        in_valid = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, out_err, out_bcd} !== 19'h0) begin
            errors++;
            $display("FAIL midreset_outputs: ready=%b valid=%b err=%b bcd=%h required 0/0/0/0000",
                     in_ready, out_valid, out_err, out_bcd);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        send_frame(16'b1000_1001_1010_1011, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_bcd !== 16'h5678 || out_err !== 1'b0) begin
            errors++;
            $display("FAIL midreset_frame: valid=%b bcd=%h err=%b required 1/5678/0", out_valid, out_bcd, out_err);
        end
        do_handshake("midreset");
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_basic();
        test_boundary();
        test_error();
        test_backpressure();
        test_gaps();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
